// File: rtl/p2s_pkg.sv
// Shared definitions for the p2s_tx parallel-to-serial transmitter.
package p2s_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_STROBE = 2'd2,
        S_GAP    = 2'd3
    } p2s_state_t;

    localparam int STB_CNT_W = 4;
    localparam int GAP_CNT_W = 8;

endpackage

// File: rtl/p2s_cnt.sv
// Loadable down-counter with zero flag; load wins over decrement, never wraps below zero.
module p2s_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter feeding an s2p_w_oe chain: shift, strobe, optional gap.
// Define P2S_TX_LSB_FIRST_EN to send bit 0 first instead of the MSB.
module p2s_tx
    import p2s_pkg::*;
#(
    parameter int DW    = 16,
    parameter int STB_W = 1,
    parameter int GAP   = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          sout,
    output logic          st_clk,
    output logic          busy,
    output logic          frame_done
);

    localparam int BIT_W = $clog2(DW);
    localparam logic [BIT_W-1:0]     BIT_LOAD = BIT_W'(DW - 1);
    // Strobe counter runs one short: frame_done is raised when it hits zero, exit follows.
    localparam logic [STB_CNT_W-1:0] STB_LOAD = STB_CNT_W'((STB_W >= 2) ? (STB_W - 2) : 0);
    localparam logic [GAP_CNT_W-1:0] GAP_LOAD = GAP_CNT_W'((GAP >= 1) ? (GAP - 1) : 0);

    p2s_state_t    state;
    logic [DW-1:0] shreg;
    logic [DW-1:0] load_rest;
    logic [DW-1:0] shifted;
    logic          load_bit;
    logic          cur_bit;
    logic          bit_zero;
    logic          stb_zero;
    logic          gap_zero;

`ifdef P2S_TX_LSB_FIRST_EN
    assign load_bit  = in_data[0];
    assign load_rest = in_data >> 1;
    assign cur_bit   = shreg[0];
    assign shifted   = shreg >> 1;
`else
    assign load_bit  = in_data[DW-1];
    assign load_rest = in_data << 1;
    assign cur_bit   = shreg[DW-1];
    assign shifted   = shreg << 1;
`endif

    p2s_cnt #(.W(BIT_W)) u_bit_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == S_IDLE) && in_valid),
        .dec      (state == S_SHIFT),
        .load_val (BIT_LOAD),
        .zero     (bit_zero)
    );

    p2s_cnt #(.W(STB_CNT_W)) u_stb_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == S_SHIFT) && bit_zero),
        .dec      ((state == S_STROBE) && !frame_done),
        .load_val (STB_LOAD),
        .zero     (stb_zero)
    );

    p2s_cnt #(.W(GAP_CNT_W)) u_gap_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     ((state == S_STROBE) && frame_done),
        .dec      (state == S_GAP),
        .load_val (GAP_LOAD),
        .zero     (gap_zero)
    );

    // The first bit is presented straight from in_data so it appears the cycle after acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            shreg      <= '0;
            sout       <= 1'b0;
            st_clk     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        shreg <= load_rest;
                        sout  <= load_bit;
                        busy  <= 1'b1;
                        state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_zero) begin
                        st_clk     <= 1'b1;
                        frame_done <= (STB_W == 1);
                        state      <= S_STROBE;
                    end else begin
                        sout  <= cur_bit;
                        shreg <= shifted;
                    end
                end
                S_STROBE: begin
                    if (frame_done) begin
                        st_clk     <= 1'b0;
                        frame_done <= 1'b0;
                        sout       <= 1'b0;
                        if (GAP > 0) begin
                            state <= S_GAP;
                        end else begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end
                    end else if (stb_zero) begin
                        frame_done <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (gap_zero) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready = (state == S_IDLE);

endmodule
